// File: rtl/mult.sv
// -----------------------------------------------------------------------------
// mult: element-wise complex multiplier for N-point vectors of binary64
// complex numbers, Px[k] = Ax[k] * Bx[k]. The result is registered once, so
// latency is one clock and a full vector is accepted every clock.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears Px to +0.0, out_valid to 0)
//   in_valid   Ax/Bx hold a valid vector this cycle
//   Ax, Bx     operands, [k][0] = real, [k][1] = imag
//   Px         registered product, same layout
//   out_valid  in_valid delayed by one clock
//
// Arithmetic: every multiply and add/sub rounds to nearest-even on its own
// (no fused operation). Subnormal operands read as signed zero, subnormal
// results flush to signed zero, every NaN outcome is the canonical qNaN.
// -----------------------------------------------------------------------------
module mult #(
  parameter int N = 16,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] Ax [N][2],
  input  logic [W-1:0] Bx [N][2],
  output logic [W-1:0] Px [N][2],
  output logic         out_valid
);

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  // binary64 multiply, RNE, flush-to-zero on both inputs and output.
  function automatic logic [63:0] fp_mul64(input logic [63:0] a, input logic [63:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic sign, guard, sticky, inc;
    logic [105:0] prod;
    logic [51:0] frac;
    logic [52:0] frac_r;
    logic signed [13:0] e;
    logic [63:0] res;
    a_zero = (a[62:52] == 11'd0);
    b_zero = (b[62:52] == 11'd0);
    a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    sign   = a[63] ^ b[63];
    prod   = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    e      = $signed({3'b000, a[62:52]}) + $signed({3'b000, b[62:52]}) - 14'sd1023;
    // Product of two [1,2) significands lies in [1,4): leading one at bit 105 or 104.
    if (prod[105]) begin
      frac   = prod[104:53];
      guard  = prod[52];
      sticky = |prod[51:0];
      e      = e + 14'sd1;
    end else begin
      frac   = prod[103:52];
      guard  = prod[51];
      sticky = |prod[50:0];
    end
    inc    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {52'd0, inc};
    // A carry out of the fraction means 1.11..1 rounded up to 2.0; fraction is already 0.
    e      = e + $signed({13'd0, frac_r[52]});
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      res = QNAN;
    end else if (a_inf || b_inf) begin
      res = {sign, 11'h7FF, 52'd0};
    end else if (a_zero || b_zero) begin
      res = {sign, 63'd0};
    end else if (e >= 14'sd2047) begin
      res = {sign, 11'h7FF, 52'd0};
    end else if (e <= 14'sd0) begin
      res = {sign, 63'd0};
    end else begin
      res = {sign, e[10:0], frac_r[51:0]};
    end
    return res;
  endfunction

  // binary64 add, RNE, flush-to-zero on both inputs and output.
  function automatic logic [63:0] fp_add64(input logic [63:0] a, input logic [63:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic sticky_al, guard, sticky, inc, found;
    logic [63:0] x, y, res;
    logic [10:0] d;
    logic [55:0] mx, my, my_sh;
    logic [56:0] sum, norm;
    logic [5:0] lz;
    logic [52:0] frac_r;
    logic signed [13:0] e;
    a_zero = (a[62:52] == 11'd0);
    b_zero = (b[62:52] == 11'd0);
    a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    // x carries the larger magnitude so the aligned difference is never negative.
    if (b[62:0] > a[62:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    d  = x[62:52] - y[62:52];
    // Three extra low bits act as guard / round / sticky through alignment.
    mx = {1'b1, x[51:0], 3'b000};
    my = {1'b1, y[51:0], 3'b000};
    if (d >= 11'd56) begin
      my_sh     = 56'd0;
      sticky_al = 1'b1;
    end else begin
      my_sh     = my >> d;
      sticky_al = |(my & ((56'd1 << d) - 56'd1));
    end
    my_sh[0] = my_sh[0] | sticky_al;
    if (x[63] ^ y[63]) begin
      sum = {1'b0, mx} - {1'b0, my_sh};
    end else begin
      sum = {1'b0, mx} + {1'b0, my_sh};
    end
    lz    = 6'd0;
    found = 1'b0;
    for (int i = 56; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
      end else if (!found) begin
        lz = lz + 6'd1;
      end else begin
        lz = lz;
      end
    end
    // Leading one lands on bit 56; an all-zero sum leaves norm[56] clear.
    norm   = sum << lz;
    guard  = norm[3];
    sticky = |norm[2:0];
    inc    = guard & (sticky | norm[4]);
    frac_r = {1'b0, norm[55:4]} + {52'd0, inc};
    e      = $signed({3'b000, x[62:52]}) + 14'sd1 - $signed({8'd0, lz})
             + $signed({13'd0, frac_r[52]});
    if (a_nan || b_nan || (a_inf && b_inf && (a[63] != b[63]))) begin
      res = QNAN;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else if (a_zero && b_zero) begin
      res = {a[63] & b[63], 63'd0};
    end else if (b_zero) begin
      res = a;
    end else if (a_zero) begin
      res = b;
    end else if (!norm[56]) begin
      res = 64'd0;
    end else if (e >= 14'sd2047) begin
      res = {x[63], 11'h7FF, 52'd0};
    end else if (e <= 14'sd0) begin
      res = {x[63], 63'd0};
    end else begin
      res = {x[63], e[10:0], frac_r[51:0]};
    end
    return res;
  endfunction

  // Sign flip turns the adder into the subtractor for the real part.
  function automatic logic [63:0] fp_neg(input logic [63:0] a);
    return {~a[63], a[62:0]};
  endfunction

  logic valid_d, valid_q;

  // Valid simply follows the input one clock later.
  always_comb begin
    valid_d = in_valid;
  end

  // Valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [W-1:0] re_d, im_d, re_q, im_q;

    // Four separately rounded products, then one rounded sub (real) and add (imag).
    always_comb begin
      re_d = fp_add64(fp_mul64(Ax[k][0], Bx[k][0]), fp_neg(fp_mul64(Ax[k][1], Bx[k][1])));
      im_d = fp_add64(fp_mul64(Ax[k][0], Bx[k][1]), fp_mul64(Ax[k][1], Bx[k][0]));
    end

    // Result register; updates every clock regardless of in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        re_q <= 64'd0;
        im_q <= 64'd0;
      end else begin
        re_q <= re_d;
        im_q <= im_d;
      end
    end

    assign Px[k][0] = re_q;
    assign Px[k][1] = im_q;
  end

endmodule

// File: tb/tb_mult.sv
// -----------------------------------------------------------------------------
// tb_mult: scoreboard bench for mult. Stimulus is applied on the falling edge
// and the expected vector is queued; a monitor pops one entry after each
// rising edge and compares. Expected values come either from explicit
// constants or from a reference built on the simulator's native double
// arithmetic with flush-to-zero and NaN canonicalisation layered on top.
// -----------------------------------------------------------------------------
module tb_mult;
  localparam int N = 16;
  localparam int W = 64;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] ax [N][2];
  logic [W-1:0] bx [N][2];
  logic [W-1:0] px [N][2];
  logic         out_valid;

  // staging: next operands and (for directed vectors) their expected product
  logic [63:0] sa [N][2];
  logic [63:0] sb [N][2];
  logic [63:0] sx [N][2];

  logic               exp_v_q [$];
  logic [2*N*64-1:0]  exp_d_q [$];
  logic               mon_en;
  int                 checks;
  int                 errors;

  mult #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .Ax       (ax),
    .Bx       (bx),
    .Px       (px),
    .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] daz(input logic [63:0] v);
    if (v[62:52] == 11'd0) return {v[63], 63'd0};
    else return v;
  endfunction

  function automatic logic [63:0] canon(input real r);
    logic [63:0] b;
    b = $realtobits(r);
    if (b[62:52] == 11'h7FF && b[51:0] != 52'd0) return QNAN;
    else if (b[62:52] == 11'd0) return {b[63], 63'd0};
    else return b;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    return canon($bitstoreal(daz(a)) * $bitstoreal(daz(b)));
  endfunction

  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b);
    return canon($bitstoreal(daz(a)) + $bitstoreal(daz(b)));
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b);
    return canon($bitstoreal(daz(a)) - $bitstoreal(daz(b)));
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] rnd_fp();
    int unsigned c;
    logic [63:0] v;
    c = $urandom_range(0, 19);
    v = {$urandom, $urandom};
    if (c < 14)       v[62:52] = 11'(993 + $urandom_range(0, 60));
    else if (c == 14) v[62:0]  = 63'd0;
    else if (c == 15) v[62:0]  = {11'h7FF, 52'd0};
    else if (c == 16) v[62:0]  = {11'h7FF, v[51:1], 1'b1};
    else if (c == 17) v[62:52] = 11'd0;
    else if (c == 18) v[62:52] = 11'(1600 + $urandom_range(0, 446));
    else              v[62:52] = 11'(1 + $urandom_range(0, 400));
    return v;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 2; j++) begin
        sa[k][j] = rnd_fp();
        sb[k][j] = rnd_fp();
      end
    end
  endtask

  task automatic fill_all(input real ar, input real ai, input real br, input real bi,
                          input logic [63:0] re, input logic [63:0] im);
    for (int k = 0; k < N; k++) begin
      sa[k][0] = $realtobits(ar);
      sa[k][1] = $realtobits(ai);
      sb[k][0] = $realtobits(br);
      sb[k][1] = $realtobits(bi);
      sx[k][0] = re;
      sx[k][1] = im;
    end
  endtask

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 2; j++) begin
        ax[k][j] = sa[k][j];
        bx[k][j] = sb[k][j];
      end
    end
  endtask

  // Drive one vector on the falling edge and queue its expected product.
  task automatic send(input logic v, input logic use_model);
    logic [2*N*64-1:0] e;
    @(negedge clk);
    apply();
    in_valid = v;
    for (int k = 0; k < N; k++) begin
      if (use_model) begin
        e[(2*k)*64 +: 64]   = ref_sub(ref_mul(sa[k][0], sb[k][0]), ref_mul(sa[k][1], sb[k][1]));
        e[(2*k+1)*64 +: 64] = ref_add(ref_mul(sa[k][0], sb[k][1]), ref_mul(sa[k][1], sb[k][0]));
      end else begin
        e[(2*k)*64 +: 64]   = sx[k][0];
        e[(2*k+1)*64 +: 64] = sx[k][1];
      end
    end
    exp_v_q.push_back(v);
    exp_d_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_v_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_v_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never produced, required 0 pending", exp_v_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (px[k][j] !== 64'd0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_px: %0d words nonzero (e.g. Px[0][0]=%h), required all 64'h0", tag, bad, px[0][0]);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_out_valid: got %b, required 0", tag, out_valid);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic              ev;
    logic [2*N*64-1:0] ed;
    logic              bad;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rst_n && exp_v_q.size() != 0) begin
        ev = exp_v_q.pop_front();
        ed = exp_d_q.pop_front();
        checks++;
        if (out_valid !== ev) begin
          errors++;
          $display("FAIL out_valid @%0t: got %b, required %b", $time, out_valid, ev);
        end
        if (ev) begin
          bad = 1'b0;
          for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 2; j++) begin
              if (px[k][j] !== ed[(2*k+j)*64 +: 64] && !bad) begin
                bad = 1'b1;
                $display("FAIL Px[%0d][%0d] @%0t: got %h, required %h",
                         k, j, $time, px[k][j], ed[(2*k+j)*64 +: 64]);
              end
            end
          end
          checks++;
          if (bad) errors++;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    fill_random();
    apply();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // first vector after reset release
    fill_random();
    send(1'b1, 1'b1);

    // real ramp: 2k * (2k+1)
    for (int k = 0; k < N; k++) begin
      sa[k][0] = $realtobits(real'(2 * k));
      sa[k][1] = 64'd0;
      sb[k][0] = $realtobits(real'(2 * k + 1));
      sb[k][1] = 64'd0;
      sx[k][0] = $realtobits(real'(2 * k * (2 * k + 1)));
      sx[k][1] = 64'd0;
    end
    send(1'b1, 1'b0);

    // (1+2i)(3+4i) = -5+10i
    fill_all(1.0, 2.0, 3.0, 4.0, 64'hC014_0000_0000_0000, 64'h4024_0000_0000_0000);
    send(1'b1, 1'b0);
    // (2i)(3i) = -6+0i
    fill_all(0.0, 2.0, 0.0, 3.0, 64'hC018_0000_0000_0000, 64'd0);
    send(1'b1, 1'b0);
    // Inf * 0 -> qNaN in both parts
    fill_all(1.0, 0.0, 0.0, 0.0, QNAN, QNAN);
    for (int k = 0; k < N; k++) sa[k][0] = 64'h7FF0_0000_0000_0000;
    send(1'b1, 1'b0);
    // overflow -> +Inf
    fill_all(1.0e200, 0.0, 1.0e200, 0.0, 64'h7FF0_0000_0000_0000, 64'd0);
    send(1'b1, 1'b0);
    // underflow -> +0
    fill_all(1.0e-200, 0.0, 1.0e-200, 0.0, 64'd0, 64'd0);
    send(1'b1, 1'b0);
    // subnormal operand reads as +0: (+0)(-1) - 0*0 = -0, imag +0
    fill_all(0.0, 0.0, -1.0, 0.0, 64'h8000_0000_0000_0000, 64'd0);
    for (int k = 0; k < N; k++) sa[k][0] = 64'h0000_0000_0000_0001;
    send(1'b1, 1'b0);
    // NaN operand -> canonical qNaN
    fill_all(0.0, 1.0, 1.0, 1.0, QNAN, QNAN);
    for (int k = 0; k < N; k++) sa[k][0] = 64'hFFF0_0000_0000_0001;
    send(1'b1, 1'b0);
    // exact cancellation in real part gives +0
    fill_all(1.75, 1.75, -3.0, -3.0, 64'd0, $realtobits(-10.5));
    send(1'b1, 1'b0);

    // randomized stream with toggling in_valid
    repeat (200) begin
      fill_random();
      send(1'($urandom_range(0, 1)), 1'b1);
    end

    // leave a nonzero valid result in the register, then reset mid-cycle
    fill_all(1.0, 2.0, 3.0, 4.0, 64'hC014_0000_0000_0000, 64'h4024_0000_0000_0000);
    send(1'b1, 1'b0);
    drain();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    send(1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
